// File: rtl/mmio_uart.sv
// mmio_uart: memory-mapped UART with TX/RX FIFOs, programmable baud divisor
// and sticky error flags. Registers: DATA at BASE_ADDR, STATUS at +1, DIV at +2.
// Optional build macro UART_PARITY_EN adds an even-parity bit (11-bit frame);
// without it frames are 10 bits and par_err reads 0.
module mmio_uart #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_C004,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  input  logic        rxd,
  output logic        txd,
  output logic        rx_avail
);

  localparam int         PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0] DEPTH4 = 4'(FIFO_DEPTH);

  // Pointer advance with explicit wrap so any depth up to 8 behaves as a ring.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // ---------------- address decode and bus strobes ----------------
  logic sel_data, sel_stat, sel_div;
  assign sel_data = (addr == BASE_ADDR);
  assign sel_stat = (addr == BASE_ADDR + 32'd1);
  assign sel_div  = (addr == BASE_ADDR + 32'd2);
  assign hit      = sel_data | sel_stat | sel_div;

  logic wr_data, wr_stat, wr_div, rd_pop;
  logic [3:0] tx_cnt_q, rx_cnt_q;
  assign wr_data = we & sel_data;
  assign wr_stat = we & sel_stat;
  assign wr_div  = we & sel_div;
  // A simultaneous write wins over the read side effect.
  assign rd_pop  = re & ~we & sel_data & (rx_cnt_q != 4'd0);

  // ---------------- baud divisor ----------------
  logic [15:0] div_q;

  // Divisor register, clamped to a minimum of 4 clocks per bit.
  always_ff @(posedge clk) begin
    if (rst)
      div_q <= DEFAULT_DIV;
    else if (wr_div)
      div_q <= (wdata[15:0] < 16'd4) ? 16'd4 : wdata[15:0];
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [PW-1:0] tx_wp_q, tx_rp_q;
  logic          tx_push, tx_pop;
  logic [7:0]    tx_head;

  assign tx_push = wr_data & (tx_cnt_q != DEPTH4);
  assign tx_head = tx_mem_q[tx_rp_q];

  // TX storage array (no reset so it maps to plain memory).
  always_ff @(posedge clk) begin
    if (tx_push)
      tx_mem_q[tx_wp_q] <= wdata[7:0];
  end

  // TX ring pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= 4'd0;
    end else begin
      if (tx_push) tx_wp_q <= ptr_inc(tx_wp_q);
      if (tx_pop)  tx_rp_q <= ptr_inc(tx_rp_q);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_q <= tx_cnt_q + 4'd1;
        2'b01:   tx_cnt_q <= tx_cnt_q - 4'd1;
        default: tx_cnt_q <= tx_cnt_q;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PAR,
`endif
    TX_STOP
  } tx_state_t;

  tx_state_t   tx_state_q;
  logic [15:0] tx_tmr_q, tx_div_q;
  logic [7:0]  tx_shift_q;
  logic [2:0]  tx_bit_q;
  logic        tx_par_q;
  logic        txd_q;

  // A new byte is taken from idle, or straight out of the stop bit so that
  // consecutive bytes leave no extra idle time.
  assign tx_pop = (tx_cnt_q != 4'd0) &&
                  ((tx_state_q == TX_IDLE) ||
                   ((tx_state_q == TX_STOP) && (tx_tmr_q == 16'd0)));

  // Transmit sequencer: start, 8 data bits LSB first, optional parity, stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_tmr_q   <= 16'd0;
      tx_div_q   <= DEFAULT_DIV;
      tx_shift_q <= 8'd0;
      tx_bit_q   <= 3'd0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_START: begin
          if (tx_tmr_q == 16'd0) begin
            txd_q      <= tx_shift_q[0];
            tx_tmr_q   <= tx_div_q - 16'd1;
            tx_bit_q   <= 3'd0;
            tx_state_q <= TX_DATA;
          end else begin
            tx_tmr_q <= tx_tmr_q - 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_tmr_q == 16'd0) begin
            tx_tmr_q <= tx_div_q - 16'd1;
            if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
              txd_q      <= tx_par_q;
              tx_state_q <= TX_PAR;
`else
              txd_q      <= 1'b1;
              tx_state_q <= TX_STOP;
`endif
            end else begin
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              txd_q      <= tx_shift_q[1];
              tx_bit_q   <= tx_bit_q + 3'd1;
            end
          end else begin
            tx_tmr_q <= tx_tmr_q - 16'd1;
          end
        end
`ifdef UART_PARITY_EN
        TX_PAR: begin
          if (tx_tmr_q == 16'd0) begin
            txd_q      <= 1'b1;
            tx_tmr_q   <= tx_div_q - 16'd1;
            tx_state_q <= TX_STOP;
          end else begin
            tx_tmr_q <= tx_tmr_q - 16'd1;
          end
        end
`endif
        default: begin
          // TX_IDLE and TX_STOP: both may launch the next byte.
          if ((tx_state_q == TX_STOP) && (tx_tmr_q != 16'd0)) begin
            tx_tmr_q <= tx_tmr_q - 16'd1;
          end else if (tx_pop) begin
            tx_shift_q <= tx_head;
            tx_par_q   <= ^tx_head;
            tx_div_q   <= div_q;
            tx_tmr_q   <= div_q - 16'd1;
            txd_q      <= 1'b0;
            tx_state_q <= TX_START;
          end else begin
            txd_q      <= 1'b1;
            tx_state_q <= TX_IDLE;
          end
        end
      endcase
    end
  end

  assign txd = txd_q;

  // ---------------- RX synchronizer ----------------
  logic rx_s1_q, rx_s2_q, rx_s3_q;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= rxd;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  // ---------------- RX FSM ----------------
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PAR,
`endif
    RX_STOP
  } rx_state_t;

  rx_state_t   rx_state_q;
  logic [15:0] rx_tmr_q, rx_div_q;
  logic [7:0]  rx_shift_q;
  logic [2:0]  rx_bit_q;
  logic        rx_par_ok;

`ifdef UART_PARITY_EN
  logic rx_par_bad_q;
  assign rx_par_ok = ~rx_par_bad_q;
`else
  assign rx_par_ok = 1'b1;
`endif

  // Receive sequencer: mid-bit sampling, start-bit glitch rejection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_tmr_q   <= 16'd0;
      rx_div_q   <= DEFAULT_DIV;
      rx_shift_q <= 8'd0;
      rx_bit_q   <= 3'd0;
`ifdef UART_PARITY_EN
      rx_par_bad_q <= 1'b0;
`endif
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_s3_q && !rx_s2_q) begin
            rx_div_q   <= div_q;
            rx_tmr_q   <= {1'b0, div_q[15:1]} - 16'd1;
            rx_state_q <= RX_START;
`ifdef UART_PARITY_EN
            rx_par_bad_q <= 1'b0;
`endif
          end
        end
        RX_START: begin
          if (rx_tmr_q == 16'd0) begin
            if (rx_s2_q) begin
              rx_state_q <= RX_IDLE;
            end else begin
              rx_tmr_q   <= rx_div_q - 16'd1;
              rx_bit_q   <= 3'd0;
              rx_state_q <= RX_DATA;
            end
          end else begin
            rx_tmr_q <= rx_tmr_q - 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_tmr_q == 16'd0) begin
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            rx_tmr_q   <= rx_div_q - 16'd1;
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
              rx_state_q <= RX_PAR;
`else
              rx_state_q <= RX_STOP;
`endif
            end
          end else begin
            rx_tmr_q <= rx_tmr_q - 16'd1;
          end
        end
`ifdef UART_PARITY_EN
        RX_PAR: begin
          if (rx_tmr_q == 16'd0) begin
            rx_par_bad_q <= (rx_s2_q != ^rx_shift_q);
            rx_tmr_q     <= rx_div_q - 16'd1;
            rx_state_q   <= RX_STOP;
          end else begin
            rx_tmr_q <= rx_tmr_q - 16'd1;
          end
        end
`endif
        default: begin
          // RX_STOP: back to idle right after the mid-bit sample.
          if (rx_tmr_q == 16'd0)
            rx_state_q <= RX_IDLE;
          else
            rx_tmr_q <= rx_tmr_q - 16'd1;
        end
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic          rx_stop_tick, rx_good, rx_push, ovf_set, frm_set;
  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [PW-1:0] rx_wp_q, rx_rp_q;

  assign rx_stop_tick = (rx_state_q == RX_STOP) && (rx_tmr_q == 16'd0);
  assign rx_good      = rx_stop_tick & rx_s2_q & rx_par_ok;
  assign rx_push      = rx_good & (rx_cnt_q != DEPTH4);
  assign ovf_set      = rx_good & (rx_cnt_q == DEPTH4);
  assign frm_set      = rx_stop_tick & ~rx_s2_q;

  // RX storage array.
  always_ff @(posedge clk) begin
    if (rx_push)
      rx_mem_q[rx_wp_q] <= rx_shift_q;
  end

  // RX ring pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= 4'd0;
    end else begin
      if (rx_push) rx_wp_q <= ptr_inc(rx_wp_q);
      if (rd_pop)  rx_rp_q <= ptr_inc(rx_rp_q);
      case ({rx_push, rd_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + 4'd1;
        2'b01:   rx_cnt_q <= rx_cnt_q - 4'd1;
        default: rx_cnt_q <= rx_cnt_q;
      endcase
    end
  end

  // ---------------- sticky flags ----------------
  logic rx_ovf_q, frm_err_q, par_err;

  // Sticky error flags: write-1-to-clear, a new event in the same cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ovf_q  <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      rx_ovf_q  <= ovf_set | (rx_ovf_q  & ~(wr_stat & wdata[8]));
      frm_err_q <= frm_set | (frm_err_q & ~(wr_stat & wdata[9]));
    end
  end

`ifdef UART_PARITY_EN
  logic par_err_q, par_set;
  assign par_set = (rx_state_q == RX_PAR) && (rx_tmr_q == 16'd0) &&
                   (rx_s2_q != ^rx_shift_q);

  // Sticky parity error flag.
  always_ff @(posedge clk) begin
    if (rst)
      par_err_q <= 1'b0;
    else
      par_err_q <= par_set | (par_err_q & ~(wr_stat & wdata[10]));
  end
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  // ---------------- read mux ----------------
  logic [3:0] tx_free;
  assign tx_free  = DEPTH4 - tx_cnt_q;
  assign rx_avail = (rx_cnt_q != 4'd0);

  // Combinational register read, decoded purely from addr.
  always_comb begin
    rdata = 32'h0000_DEAD;
    if (sel_data)
      rdata = rx_avail ? {24'b0, rx_mem_q[rx_rp_q]} : 32'h0;
    else if (sel_stat)
      rdata = {21'b0, par_err, frm_err_q, rx_ovf_q, rx_cnt_q, tx_free};
    else if (sel_div)
      rdata = {16'b0, div_q};
  end

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:16];

endmodule

// File: tb/tb_mmio_uart.sv
// tb_mmio_uart: directed self-checking bench for mmio_uart (default build).
module tb_mmio_uart;

  localparam logic [31:0] A_DATA = 32'h0000_C004;
  localparam logic [31:0] A_STAT = 32'h0000_C005;
  localparam logic [31:0] A_DIV  = 32'h0000_C006;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = A_DATA;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        hit;
  logic        rxd;
  logic        txd;
  logic        rx_avail;
  logic        rxd_drv = 1'b1;
  logic        loop_en = 1'b0;

  int checks = 0;
  int errors = 0;

  assign rxd = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;

  mmio_uart dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .re       (re),
    .we       (we),
    .wdata    (wdata),
    .rdata    (rdata),
    .hit      (hit),
    .rxd      (rxd),
    .txd      (txd),
    .rx_avail (rx_avail)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s = %h", tag, obs);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic pop, output logic [31:0] d);
    @(negedge clk);
    addr = a; re = pop;
    #1 d = rdata;
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int div);
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      repeat (div) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rxd_drv = ^b;
    repeat (div) @(negedge clk);
`endif
    rxd_drv = stop_bit;
    repeat (div) @(negedge clk);
    rxd_drv = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  tx_byte;
    int          low_cnt;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rd(A_STAT, 1'b0, d);  check_eq("rst_status", d, 32'h0000_0008);
    rd(A_DIV, 1'b0, d);   check_eq("rst_div", d, 32'h0000_01B2);
    check_eq("hit_div", {31'b0, hit}, 32'd1);
    rd(32'h0000_C00F, 1'b0, d); check_eq("unmapped_rdata", d, 32'h0000_DEAD);
    check_eq("unmapped_hit", {31'b0, hit}, 32'd0);
    check_eq("rst_txd", {31'b0, txd}, 32'd1);
    check_eq("rst_rx_avail", {31'b0, rx_avail}, 32'd0);

    // Single TX frame, DIV=16, byte 0xA5
    wr(A_DIV, 32'd16);
    wr(A_DATA, 32'h0000_00A5);
    addr = A_STAT;
    #1 check_eq("tx_free_queued", {28'b0, rdata[3:0]}, 32'd7);
    for (int i = 0; i < 20 && txd; i++) @(negedge clk);
    check_eq("tx_start_edge", {31'b0, txd}, 32'd0);
    check_eq("tx_free_popped", {28'b0, rdata[3:0]}, 32'd8);
    repeat (8) @(negedge clk);
    check_eq("tx_start_mid", {31'b0, txd}, 32'd0);
    tx_byte = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(negedge clk);
      check_eq($sformatf("tx_bit%0d", i), {31'b0, txd}, {31'b0, tx_byte[i]});
    end
`ifdef UART_PARITY_EN
    repeat (16) @(negedge clk);
    check_eq("tx_parity", {31'b0, txd}, {31'b0, ^tx_byte});
`endif
    repeat (16) @(negedge clk);
    check_eq("tx_stop", {31'b0, txd}, 32'd1);
    repeat (16) @(negedge clk);
    check_eq("tx_idle", {31'b0, txd}, 32'd1);

    // Loopback, DIV=8, byte 0x3C
    loop_en = 1'b1;
    wr(A_DIV, 32'd8);
    wr(A_DATA, 32'h0000_003C);
    for (int i = 0; i < 300 && !rx_avail; i++) @(negedge clk);
    check_eq("lb_rx_avail", {31'b0, rx_avail}, 32'd1);
    rd(A_DATA, 1'b1, d);  check_eq("lb_data", d, 32'h0000_003C);
    check_eq("lb_rx_avail_clr", {31'b0, rx_avail}, 32'd0);

    // Nine bytes into RX without reads -> overflow
    for (int b = 0; b < 9; b++) wr(A_DATA, 32'h11 + b);
    addr = A_STAT;
    #1;
    for (int i = 0; i < 2000 && !rdata[8]; i++) @(negedge clk);
    repeat (100) @(negedge clk);
    check_eq("ovf_status", rdata, 32'h0000_0188);
    wr(A_STAT, 32'h0000_0100);
    rd(A_STAT, 1'b0, d);  check_eq("ovf_w1c", d, 32'h0000_0088);
    for (int b = 0; b < 8; b++) begin
      rd(A_DATA, 1'b1, d);
      check_eq($sformatf("ovf_pop%0d", b), d, 32'h11 + b);
    end
    rd(A_STAT, 1'b0, d);  check_eq("ovf_drained", d, 32'h0000_0008);

    // Glitch rejection, DIV=16
    loop_en = 1'b0;
    wr(A_DIV, 32'd16);
    @(negedge clk); rxd_drv = 1'b0;
    repeat (2) @(negedge clk); rxd_drv = 1'b1;
    repeat (40) @(negedge clk);
    rd(A_STAT, 1'b0, d);  check_eq("glitch_status", d, 32'h0000_0008);

    // Bit-banged good frame
    send_frame(8'h5A, 1'b1, 16);
    repeat (32) @(negedge clk);
    rd(A_STAT, 1'b0, d);  check_eq("rx_good_status", d, 32'h0000_0018);
    rd(A_DATA, 1'b1, d);  check_eq("rx_good_data", d, 32'h0000_005A);

    // Framing error: stop bit low
    send_frame(8'hC3, 1'b0, 16);
    repeat (32) @(negedge clk);
    rd(A_STAT, 1'b0, d);  check_eq("frm_status", d, 32'h0000_0208);
    wr(A_STAT, 32'h0000_0200);
    rd(A_STAT, 1'b0, d);  check_eq("frm_w1c", d, 32'h0000_0008);

    // Divisor clamp
    wr(A_DIV, 32'd1);
    rd(A_DIV, 1'b0, d);   check_eq("div_clamp", d, 32'h0000_0004);

    // Reset in the middle of a TX frame with 3 bytes queued
    wr(A_DIV, 32'd16);
    for (int b = 0; b < 4; b++) wr(A_DATA, 32'h55 + b);
    repeat (30) @(negedge clk);
    addr = A_STAT;
    #1 check_eq("midtx_tx_free", rdata, 32'h0000_0005);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check_eq("midtx_rst_txd", {31'b0, txd}, 32'd1);
    check_eq("midtx_rst_status", rdata, 32'h0000_0008);
    check_eq("midtx_rst_rx_avail", {31'b0, rx_avail}, 32'd0);
    rst = 1'b0;
    low_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!txd) low_cnt++;
    end
    check_eq("midtx_no_tx", low_cnt, 32'd0);
    rd(A_DIV, 1'b0, d);   check_eq("midtx_div", d, 32'h0000_01B2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_uart.md
Name: mmio_uart

Overview:
- Memory-mapped UART peripheral on the CPU's external data bus (addr/re/we/wdata/rdata), downstream of the CPU's EX_DM stage.
- Gives the handwriting-recognition firmware a serial path: image upload in, classification results out.
- TX and RX FIFOs, a programmable baud divisor and sticky error flags.
- Top level ORs/muxes `rdata` using the `hit` output.

Parameters:
- BASE_ADDR, 32'h0000_C004: address of DATA register. STATUS is BASE_ADDR+1, DIV is BASE_ADDR+2.
- FIFO_DEPTH, 8: entries per FIFO. Must be a power of 2, at most 8.
- DEFAULT_DIV, 16'd434: reset baud divisor in clocks per bit (50 MHz / 115200).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- addr  in  32  CPU data address
- re  in  1  CPU read enable
- we  in  1  CPU write enable
- wdata  in  32  CPU write data
- rdata  out  32  read data, combinational from addr
- hit  out  1  addr within BASE_ADDR..BASE_ADDR+2
- rxd  in  1  serial input, asynchronous
- txd  out  1  serial output, idles high
- rx_avail  out  1  RX FIFO non-empty

Behaviour:
- Reset (sync, rst=1 at posedge):
  - FIFOs empty; sticky flags cleared; DIV=DEFAULT_DIV.
  - TX and RX FSMs go to IDLE; txd=1 from the next edge.
  - rx_avail=0. This holds even when reset arrives mid-frame.
- rdata:
  - DATA: {24'b0, RX head byte}, or 32'h0 if RX FIFO empty.
  - STATUS: {21'b0, par_err[10], frm_err[9], rx_ovf[8], rx_cnt[7:4], tx_free[3:0]}.
  - DIV: {16'b0, div}.
  - Unmapped: 32'h0000_DEAD with hit=0.
- Bus access is single-cycle and side effects commit at posedge:
  - we at DATA pushes wdata[7:0] to TX FIFO. If full, the byte is dropped silently.
  - re at DATA pops the RX FIFO if non-empty.
  - we at STATUS: write-1-to-clear on bits 10:8.
  - we at DIV stores wdata[15:0]. Values below 4 are stored as 4.
  - re and we both high: the write is performed and no pop occurs.
- FIFOs: circular buffers with a count.
  - Push and pop in the same cycle both take effect and the count is unchanged.
  - A push to a full FIFO is blocked. A pop from an empty FIFO is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- TX FSM: IDLE -> START -> DATA(8, LSB first) -> [PARITY] -> STOP -> IDLE.
  - Leaves IDLE when the TX FIFO is non-empty. Pops the FIFO and latches div on that edge.
  - Each bit lasts div clocks, counted by a 16-bit down counter.
  - Back-to-back bytes produce no idle gap beyond the STOP bit.
- RX path: rxd passes through a 2-flop synchronizer.
  - IDLE -> START on a sampled falling edge; div is latched.
  - START samples at div/2 (integer). If the sample is high, it was a glitch: return to IDLE.
  - DATA samples 8 bits every div clocks, then [PARITY], then STOP.
  - STOP low: frm_err set and byte discarded. STOP high: byte pushed.
  - If the RX FIFO is full at push: byte discarded and rx_ovf set.
  - Returns to IDLE after the STOP sample, so it can resync on the next falling edge.
- DIV writes during a frame affect only subsequent frames.

Optional Feature:
- UART_PARITY_EN defined:
  - TX inserts an even-parity bit after DATA.
  - RX samples a parity bit. On mismatch it sets par_err and discards the byte.
  - Frame is 11 bits.
- UART_PARITY_EN undefined:
  - No PARITY state; 10-bit frame.
  - par_err reads constant 0.

Test Plan:
- Reset, then read BASE+1 -> rdata=32'h0000_0008 (tx_free=8, rx_cnt=0). Read BASE+2 -> 32'h0000_01B2. Read 0xC00F -> 32'h0000_DEAD, hit=0. txd=1.
- Write DIV=16; write DATA=0xA5 -> txd low for 16 clks, then bits 1,0,1,0,0,1,0,1 at 16 clks each, then high stop. tx_free returns to 8 once the byte is popped.
- Loop txd to rxd, DIV=8, write 0x3C -> rx_avail rises after the frame; read DATA -> 0x0000_003C; rx_avail=0.
- Send 9 bytes into RX with no reads -> rx_cnt=8 and STATUS[8]=1. Write STATUS with 0x100 -> bit 8 cleared. First read returns the first byte sent.
- Drive rxd low for 2 clks with DIV=16 -> no byte received and no frm_err. Send a frame with stop=0 -> STATUS[9]=1 and rx_cnt unchanged.
- Assert rst mid-TX-frame with 3 bytes queued -> next cycle txd=1, tx_free=8. No further transmission.
